// File: rtl/char_code_fifo.sv
`default_nettype none
// ============================================================================
// Module   : char_code_fifo
// Purpose  : ASCII-to-glyph-code encoder feeding a first-word-fall-through
//            FIFO, with optional case folding, optional dropping of
//            unsupported characters and a saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module char_code_fifo #(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 in_char,
  input  logic                       fold_case,
  input  logic                       drop_invalid,
  input  logic                       flush,
  input  logic                       clear_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CODE_W-1:0]          out_code,
  output logic                       out_invalid,
  output logic [$clog2(DEPTH):0]     level,
  output logic [ERR_W-1:0]           err_count
);

  localparam int                AW        = $clog2(DEPTH);
  localparam logic [AW:0]       c_full    = (AW+1)'(DEPTH);
  localparam logic [ERR_W-1:0]  c_err_max = '1;

  // Storage entry is {invalid, code}
  logic [CODE_W:0]      r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_level;
  logic [ERR_W-1:0]     r_err;

  logic [6:0]           w_ch;
  logic [3:0]           w_idx;
  logic                 w_inv;
  logic [CODE_W-1:0]    w_code;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;

  // Optional case folding followed by the glyph lookup table
  always_comb begin
    w_ch  = in_char;
    w_idx = 4'd0;
    w_inv = 1'b0;
    if (fold_case && (in_char >= 7'h61) && (in_char <= 7'h7A))
      w_ch = in_char - 7'h20;
    case (w_ch)
      7'h41:   w_idx = 4'd0;   // A
      7'h43:   w_idx = 4'd1;   // C
      7'h44:   w_idx = 4'd2;   // D
      7'h45:   w_idx = 4'd3;   // E
      7'h49:   w_idx = 4'd4;   // I
      7'h4A:   w_idx = 4'd5;   // J
      7'h4D:   w_idx = 4'd6;   // M
      7'h4F:   w_idx = 4'd7;   // O
      7'h50:   w_idx = 4'd8;   // P
      7'h52:   w_idx = 4'd9;   // R
      7'h54:   w_idx = 4'd10;  // T
      default: w_inv = 1'b1;
    endcase
  end

  assign w_code  = w_inv ? {CODE_W{1'b1}} : CODE_W'(w_idx);
  assign w_full  = (r_level == c_full);
  assign w_empty = (r_level == '0);

  // Handshake flags depend only on registered state, flush and reset
  assign in_ready  = rst_n && !w_full && !flush;
  assign out_valid = !w_empty;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && !(w_inv && drop_invalid);
  assign w_pop    = out_valid && out_ready && !flush;

  assign out_code    = w_empty ? {CODE_W{1'b1}} : r_mem[r_rptr][CODE_W-1:0];
  assign out_invalid = w_empty ? 1'b0 : r_mem[r_rptr][CODE_W];
  assign level       = r_level;
  assign err_count   = r_err;

  // Entry storage; contents are only meaningful below the occupancy level
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {w_inv, w_code};
  end

  // Pointers and occupancy; flush empties the queue and voids any pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_level <= r_level + 1'b1;
      else if (!w_push && w_pop)
        r_level <= r_level - 1'b1;
    end
  end

  // Saturating count of accepted unsupported characters, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= '0;
    else if (clear_err)
      r_err <= '0;
    else if (w_accept && w_inv && (r_err != c_err_max))
      r_err <= r_err + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_char_code_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_code_fifo
// Purpose  : Directed self-checking bench for char_code_fifo (DEPTH=8,
//            CODE_W=4, ERR_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_code_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_char;
  logic       fold_case;
  logic       drop_invalid;
  logic       flush;
  logic       clear_err;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_code;
  logic       out_invalid;
  logic [3:0] level;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;

  char_code_fifo #(.DEPTH(8), .CODE_W(4), .ERR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_char      (in_char),
    .fold_case    (fold_case),
    .drop_invalid (drop_invalid),
    .flush        (flush),
    .clear_err    (clear_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_invalid  (out_invalid),
    .level        (level),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] seq [11];
    seq = '{7'h41, 7'h43, 7'h44, 7'h45, 7'h49, 7'h4A, 7'h4D, 7'h4F, 7'h50, 7'h52, 7'h54};

    rst_n = 1'b0; in_valid = 1'b0; in_char = 7'h41; fold_case = 1'b0;
    drop_invalid = 1'b0; flush = 1'b0; clear_err = 1'b0; out_ready = 1'b0;

    // Reset values
    #3;
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_code", 32'(out_code), 32'hF);
    check("rst_out_invalid", 32'(out_invalid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_err", 32'(err_count), 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Full lookup stream with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_char = seq[i];
      tick();
      check($sformatf("seq_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("seq_code_%0d", i), 32'(out_code), 32'(i));
      check($sformatf("seq_inv_%0d", i), 32'(out_invalid), 0);
      check($sformatf("seq_level_%0d", i), 32'(level), 1);
    end
    in_valid = 1'b0;
    tick();
    check("seq_drain_valid", 32'(out_valid), 0);
    check("seq_drain_code", 32'(out_code), 32'hF);
    check("seq_err", 32'(err_count), 0);

    // Fill to DEPTH with consumer stalled, then drain
    out_ready = 1'b0; in_valid = 1'b1; in_char = 7'h41;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("fill_ready_%0d", i), 32'(in_ready), 1);
      tick();
    end
    check("full_level", 32'(level), 8);
    check("full_in_ready", 32'(in_ready), 0);
    tick();
    check("full_level_hold", 32'(level), 8);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("full_pop_ready_still0", 32'(in_ready), 0);
    check("full_head_code", 32'(out_code), 0);
    tick();
    check("first_pop_level", 32'(level), 7);
    check("first_pop_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("drain_code_%0d", i), 32'(out_code), 0);
      tick();
    end
    check("drain_level", 32'(level), 0);
    check("drain_valid", 32'(out_valid), 0);

    // Case folding
    out_ready = 1'b0; fold_case = 1'b1; in_valid = 1'b1; in_char = 7'h6D;
    tick();
    in_valid = 1'b0;
    check("fold_code", 32'(out_code), 6);
    check("fold_inv", 32'(out_invalid), 0);
    check("fold_err", 32'(err_count), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; fold_case = 1'b0; in_valid = 1'b1; in_char = 7'h6D;
    tick();
    in_valid = 1'b0;
    check("nofold_code", 32'(out_code), 32'hF);
    check("nofold_inv", 32'(out_invalid), 1);
    check("nofold_err", 32'(err_count), 1);
    out_ready = 1'b1;
    tick();
    check("nofold_pop_level", 32'(level), 0);

    // Drop mode and error saturation
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clear_err", 32'(err_count), 0);
    drop_invalid = 1'b1; in_valid = 1'b1; in_char = 7'h41;
    tick();
    check("drop_A_code", 32'(out_code), 0);
    in_char = 7'h5A;
    tick();
    check("drop_Z_valid", 32'(out_valid), 0);
    check("drop_Z_err", 32'(err_count), 1);
    in_char = 7'h54;
    tick();
    check("drop_T_code", 32'(out_code), 10);
    check("drop_T_level", 32'(level), 1);
    in_char = 7'h5A;
    for (int i = 0; i < 253; i++) tick();
    check("err_254", 32'(err_count), 254);
    for (int i = 0; i < 6; i++) tick();
    check("err_sat", 32'(err_count), 255);
    check("err_sat_level", 32'(level), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0; in_valid = 1'b0;
    check("clear_vs_inc", 32'(err_count), 0);

    // Flush with concurrent input and pop request
    drop_invalid = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_char = 7'h41;
    for (int i = 0; i < 5; i++) tick();
    check("preflush_level", 32'(level), 5);
    flush = 1'b1; in_char = 7'h45; out_ready = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_level", 32'(level), 0);
    check("flush_valid", 32'(out_valid), 0);
    in_valid = 1'b1; in_char = 7'h45;
    tick();
    in_valid = 1'b0;
    check("postflush_code", 32'(out_code), 3);
    check("postflush_level", 32'(level), 1);
    out_ready = 1'b1;
    tick();

    // Asynchronous reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1; in_char = 7'h41;
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    check("prereset_level", 32'(level), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(out_valid), 0);
    check("areset_level", 32'(level), 0);
    check("areset_in_ready", 32'(in_ready), 0);
    check("areset_code", 32'(out_code), 32'hF);
    tick();
    rst_n = 1'b1;
    #1;
    check("rerelease_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_char = 7'h50;
    tick();
    in_valid = 1'b0;
    check("after_reset_code", 32'(out_code), 8);
    check("after_reset_inv", 32'(out_invalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
